fir_coeff_loader: RTL and testbench



---
 rtl/fir_pkg.sv | 17 +
 rtl/fir_coeff_loader_wait_timer.sv | 27 ++
 rtl/fir_coeff_loader.sv | 149 ++++++++++++++
 tb/tb_fir_coeff_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient loader: default sizing and the loader state enum.
package fir_pkg;

   localparam int FIR_COEFF_W   = 16;
   localparam int DEF_NUM_COEFF = 4;
   localparam int DEF_TIMEOUT   = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_BUSY,
      ST_WAIT_DONE,
      ST_DONE,
      ST_ERR
   } loader_state_t;

endpackage

// File: rtl/fir_coeff_loader_wait_timer.sv
// Handshake watchdog: synchronous-clear cycle counter whose flag marks the TIMEOUT-th counted cycle.
module wait_timer #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] count;

   // Saturates on the terminal value so a long stall cannot wrap back to a small count.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fir_coeff_loader.sv
// Snapshots a coefficient set from the host and feeds it word by word to the FIR core,
// pacing each word on the core's modwait handshake and flagging a stalled core.
module fir_coeff_loader
   import fir_pkg::*;
#(
   parameter int NUM_COEFF = DEF_NUM_COEFF,
   parameter int COEFF_W   = FIR_COEFF_W,
   parameter int TIMEOUT   = DEF_TIMEOUT,
   localparam int IDX_W    = $clog2(NUM_COEFF)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           new_coeff_set,
   input  logic [NUM_COEFF*COEFF_W-1:0]   coeff_bus,
   input  logic                           modwait,
   output logic [COEFF_W-1:0]             fir_coefficient,
   output logic                           load_coeff,
   output logic [IDX_W-1:0]               coeff_idx,
   output logic                           busy,
   output logic                           coeff_done,
   output logic                           timeout_err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFF - 1);

   loader_state_t      state;
   loader_state_t      state_next;
   logic [COEFF_W-1:0] shadow [NUM_COEFF];
   logic [IDX_W-1:0]   idx_next;
   logic [COEFF_W-1:0] word_next;
   logic               capture;
   logic               err_next;
   logic               timer_clear;
   logic               timer_en;
   logic               timer_expired;

   // Every state entry restarts the watchdog, so each handshake phase gets its own budget.
   assign timer_clear = (state_next != state);
   assign timer_en    = (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE);

   wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expired (timer_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      idx_next   = coeff_idx;
      word_next  = fir_coefficient;
      capture    = 1'b0;
      err_next   = timeout_err;

      case (state)
         ST_IDLE: begin
            // Word 0 comes straight off the bus because the shadow copy lands on the same edge.
            if (new_coeff_set && !modwait) begin
               capture    = 1'b1;
               idx_next   = '0;
               word_next  = coeff_bus[COEFF_W-1:0];
               err_next   = 1'b0;
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_next = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (modwait) begin
               state_next = ST_WAIT_DONE;
            end else if (timer_expired) begin
               state_next = ST_ERR;
            end
         end
         ST_WAIT_DONE: begin
            if (!modwait) begin
               if (coeff_idx == LAST_IDX) begin
                  state_next = ST_DONE;
               end else begin
                  idx_next   = coeff_idx + 1'b1;
                  word_next  = shadow[idx_next];
                  state_next = ST_LOAD;
               end
            end else if (timer_expired) begin
               state_next = ST_ERR;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         ST_ERR: begin
            if (!new_coeff_set) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (state_next == ST_ERR) begin
         err_next = 1'b1;
      end
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         coeff_idx       <= '0;
         fir_coefficient <= '0;
         load_coeff      <= 1'b0;
         busy            <= 1'b0;
         coeff_done      <= 1'b0;
         timeout_err     <= 1'b0;
      end else begin
         coeff_idx       <= idx_next;
         fir_coefficient <= word_next;
         load_coeff      <= (state_next == ST_LOAD);
         busy            <= (state_next != ST_IDLE);
         coeff_done      <= (state_next == ST_DONE);
         timeout_err     <= err_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_COEFF; i++) begin
            shadow[i] <= '0;
         end
      end else if (capture) begin
         for (int i = 0; i < NUM_COEFF; i++) begin
            shadow[i] <= coeff_bus[i*COEFF_W +: COEFF_W];
         end
      end
   end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed-plus-random bench for fir_coeff_loader with a core model and a word-queue reference.
module tb_fir_coeff_loader;
   import fir_pkg::*;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int TO = 64;

   logic           clk = 1'b0;
   logic           rst;
   logic           new_coeff_set;
   logic [N*W-1:0] coeff_bus;
   logic           modwait;
   logic [W-1:0]   fir_coefficient;
   logic           load_coeff;
   logic [1:0]     coeff_idx;
   logic           busy;
   logic           coeff_done;
   logic           timeout_err;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [W-1:0]   exp_q [$];
   logic [N*W-1:0] bus_at_edge;
   int  core_len   = 2;
   bit  core_en    = 1'b1;
   bit  force_busy = 1'b0;
   int  core_cnt   = 0;
   int  strobe_cnt = 0;
   int  done_cnt   = 0;
   int  last_fall  = -100;
   int  last_done_cyc = -100;

   logic [N*W-1:0] bus2;
   logic [W-1:0]   t1_words [N];
   int  s, t0, s1, prev_strobe, sets;
   bit  pending;

   fir_coeff_loader #(
      .NUM_COEFF (N),
      .COEFF_W   (W),
      .TIMEOUT   (TO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .new_coeff_set   (new_coeff_set),
      .coeff_bus       (coeff_bus),
      .modwait         (modwait),
      .fir_coefficient (fir_coefficient),
      .load_coeff      (load_coeff),
      .coeff_idx       (coeff_idx),
      .busy            (busy),
      .coeff_done      (coeff_done),
      .timeout_err     (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic [N*W-1:0] bus);
      new_coeff_set = req;
      coeff_bus     = bus;
   endtask

   // One clock: sample outputs after the edge, score strobes/done, then advance the core model.
   task automatic step();
      logic prev_load;
      logic prev_mw;
      int   exp_idx;
      prev_load   = load_coeff;
      prev_mw     = modwait;
      bus_at_edge = coeff_bus;
      @(posedge clk);
      #1;
      cyc++;
      if (load_coeff === 1'b1) begin
         strobe_cnt++;
         if (exp_q.size() == 0) begin
            for (int i = 0; i < N; i++) exp_q.push_back(bus_at_edge[i*W +: W]);
         end
         exp_idx = N - exp_q.size();
         checkOutput("strobe_idx", 64'(coeff_idx), 64'(exp_idx));
         checkOutput("strobe_word", 64'(fir_coefficient), 64'(exp_q.pop_front()));
         if (exp_idx != 0) checkOutput("strobe_after_fall", 64'(cyc), 64'(last_fall + 1));
      end
      if (coeff_done === 1'b1) begin
         done_cnt++;
         last_done_cyc = cyc;
         checkOutput("done_set_complete", 64'(exp_q.size()), 64'(0));
         checkOutput("done_after_fall", 64'(cyc), 64'(last_fall + 1));
      end
      if (prev_load === 1'b1 && core_en) core_cnt = core_len;
      else if (core_cnt > 0) core_cnt--;
      modwait = (core_cnt > 0) || force_busy;
      if (prev_mw && !modwait) last_fall = cyc;
   endtask

   // what: 0 = load strobe (idx<0 means any index), 1 = coeff_done, 2 = timeout_err
   task automatic wait_until(input string tag, input int what, input int idx, input int limit);
      bit found;
      found = 1'b0;
      for (int k = 0; k < limit && !found; k++) begin
         step();
         case (what)
            0:       found = (load_coeff === 1'b1) && (idx < 0 || int'(coeff_idx) == idx);
            1:       found = (coeff_done === 1'b1);
            default: found = (timeout_err === 1'b1);
         endcase
      end
      checkOutput(tag, 64'(found), 64'(1));
   endtask

   task automatic check_all_zero(input string pfx);
      checkOutput({pfx, "_word"}, 64'(fir_coefficient), 64'(0));
      checkOutput({pfx, "_load"}, 64'(load_coeff), 64'(0));
      checkOutput({pfx, "_idx"},  64'(coeff_idx), 64'(0));
      checkOutput({pfx, "_busy"}, 64'(busy), 64'(0));
      checkOutput({pfx, "_done"}, 64'(coeff_done), 64'(0));
      checkOutput({pfx, "_err"},  64'(timeout_err), 64'(0));
   endtask

   initial begin
      rst     = 1'b1;
      modwait = 1'b0;
      applyStimulus(1'b0, '0);
      repeat (3) step();
      check_all_zero("reset");
      rst = 1'b0;
      step();

      // Fixed set, 2-cycle modwait, request dropped after the first strobe.
      $display("[TB] basic set");
      t1_words = '{16'h0800, 16'h1000, 16'h2000, 16'h4000};
      core_len = 2;
      applyStimulus(1'b1, {16'h4000, 16'h2000, 16'h1000, 16'h0800});
      t0 = cyc;
      wait_until("t1_first", 0, 0, 5);
      checkOutput("t1_latency", 64'(cyc), 64'(t0 + 1));
      checkOutput("t1_word0", 64'(fir_coefficient), 64'(t1_words[0]));
      applyStimulus(1'b0, coeff_bus);
      prev_strobe = cyc;
      for (int k = 1; k < N; k++) begin
         wait_until("t1_strobe", 0, k, 10);
         checkOutput("t1_gap", 64'(cyc - prev_strobe), 64'(core_len + 2));
         checkOutput("t1_word", 64'(fir_coefficient), 64'(t1_words[k]));
         prev_strobe = cyc;
      end
      wait_until("t1_done", 1, -1, 10);
      checkOutput("t1_done_busy", 64'(busy), 64'(1));
      step();
      checkOutput("t1_idle_busy", 64'(busy), 64'(0));
      checkOutput("t1_done_pulse", 64'(coeff_done), 64'(0));

      // Request held off by a busy core, then atomic capture against a scribbled bus.
      $display("[TB] busy core and atomic capture");
      force_busy = 1'b1;
      modwait    = 1'b1;
      bus2 = {$urandom, $urandom};
      applyStimulus(1'b1, bus2);
      s1 = strobe_cnt;
      repeat (10) step();
      checkOutput("t2_no_strobe", 64'(strobe_cnt), 64'(s1));
      checkOutput("t2_still_idle", 64'(busy), 64'(0));
      force_busy = 1'b0;
      modwait    = 1'b0;
      step();
      checkOutput("t2_latency", 64'(load_coeff), 64'(1));
      checkOutput("t2_word0", 64'(fir_coefficient), 64'(bus2[W-1:0]));
      applyStimulus(1'b0, {(N*W){1'b1}});
      wait_until("t3_strobe3", 0, 3, 20);
      checkOutput("t3_word3", 64'(fir_coefficient), 64'(bus2[3*W +: W]));
      wait_until("t3_done", 1, -1, 10);

      // Core that never answers: timeout, hold in ERR, sticky error until the next set.
      $display("[TB] stalled core");
      step();
      core_en = 1'b0;
      applyStimulus(1'b1, {$urandom, $urandom});
      s1 = strobe_cnt;
      wait_until("t4_first", 0, 0, 5);
      s = cyc;
      wait_until("t4_err", 2, -1, TO + 16);
      checkOutput("t4_err_cycle", 64'(cyc), 64'(s + TO + 1));
      checkOutput("t4_one_strobe", 64'(strobe_cnt - s1), 64'(1));
      exp_q.delete();
      repeat (3) step();
      checkOutput("t4_err_busy", 64'(busy), 64'(1));
      checkOutput("t4_err_held", 64'(timeout_err), 64'(1));
      checkOutput("t4_no_more_strobes", 64'(strobe_cnt - s1), 64'(1));
      applyStimulus(1'b0, coeff_bus);
      step();
      checkOutput("t4_idle_busy", 64'(busy), 64'(0));
      checkOutput("t4_idle_err", 64'(timeout_err), 64'(1));
      core_en = 1'b1;
      applyStimulus(1'b1, {$urandom, $urandom});
      step();
      checkOutput("t4_restart_load", 64'(load_coeff), 64'(1));
      checkOutput("t4_err_cleared", 64'(timeout_err), 64'(0));
      applyStimulus(1'b0, coeff_bus);
      wait_until("t4_done", 1, -1, 20);

      // Reset while waiting on word 2, then a clean reload from word 0.
      $display("[TB] reset mid-set");
      step();
      core_len = 4;
      applyStimulus(1'b1, {$urandom, $urandom});
      wait_until("t5_first", 0, 0, 5);
      applyStimulus(1'b0, coeff_bus);
      wait_until("t5_word2", 0, 2, 20);
      step();
      step();
      rst = 1'b1;
      step();
      check_all_zero("t5_reset");
      exp_q.delete();
      rst = 1'b0;
      s1 = strobe_cnt;
      repeat (8) step();
      checkOutput("t5_no_strobe", 64'(strobe_cnt), 64'(s1));
      bus2 = {$urandom, $urandom};
      applyStimulus(1'b1, bus2);
      step();
      checkOutput("t5_reload_idx", 64'(coeff_idx), 64'(0));
      checkOutput("t5_reload_word", 64'(fir_coefficient), 64'(bus2[W-1:0]));
      applyStimulus(1'b0, coeff_bus);
      wait_until("t5_done", 1, -1, 40);

      // Continuous request with a randomly changing bus: back-to-back sets.
      $display("[TB] back-to-back sets");
      step();
      sets    = 0;
      pending = 1'b0;
      core_len = int'($urandom_range(1, 4));
      applyStimulus(1'b1, {$urandom, $urandom});
      for (int k = 0; k < 300 && sets < 3; k++) begin
         step();
         coeff_bus = {$urandom, $urandom};
         if (pending && load_coeff === 1'b1) begin
            checkOutput("t6_gap_after_done", 64'(cyc), 64'(last_done_cyc + 2));
            pending = 1'b0;
         end
         if (coeff_done === 1'b1) begin
            pending  = 1'b1;
            sets++;
            core_len = int'($urandom_range(1, 4));
         end
      end
      checkOutput("t6_sets", 64'(sets), 64'(3));
      wait_until("t6_next_word1", 0, 1, 40);
      applyStimulus(1'b0, {$urandom, $urandom});
      s1 = done_cnt;
      wait_until("t6_late_done", 1, -1, 60);
      checkOutput("t6_done_count", 64'(done_cnt - s1), 64'(1));
      s1 = strobe_cnt;
      repeat (6) step();
      checkOutput("t6_quiet_strobes", 64'(strobe_cnt), 64'(s1));
      checkOutput("t6_quiet_busy", 64'(busy), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
